ehl_ahb2apb_bridge: RTL and testbench

EHL_AHB2APB_BRIDGE -- requirements
Module: ehl_ahb2apb_bridge

---
 rtl/ehl_ahb2apb_bridge.sv | 156 +++++++++++++++
 tb/tb_ehl_ahb2apb_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_ahb2apb_bridge.sv
// AHB-Lite to APB4 bridge: one outstanding transfer, fully registered outputs,
// optional APB access timeout that converts a stalled completer into an AHB ERROR.
module ehl_ahb2apb_bridge #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic        hready_in,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    output logic        hready,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    output logic        psel,
    output logic        penable,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        RESP,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    logic [TW-1:0]   tcnt;
    logic            addr_valid;
    logic            unused_hprot;

    assign addr_valid   = hsel & hready_in & htrans[1];
    assign unused_hprot = ^hprot[3:2];

    function automatic logic [3:0] strb_for(input logic       wr,
                                            input logic [2:0] size,
                                            input logic [1:0] a);
        if (!wr) return 4'b0000;
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << {a[1], 1'b0};
            3'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Outputs are assigned alongside each transition so they reflect the state being entered.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state   <= IDLE;
            hready  <= 1'b1;
            hresp   <= RESP_OKAY;
            hrdata  <= '0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            pstrb   <= '0;
            pprot   <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            tcnt    <= '0;
        end else begin
            case (state)
                IDLE, RESP, ERR2: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (addr_valid) begin
                        paddr  <= haddr;
                        pwrite <= hwrite;
                        pstrb  <= strb_for(hwrite, hsize, haddr[1:0]);
                        pprot  <= {~hprot[0], 1'b1, hprot[1]};
                        hready <= 1'b0;
                        if (hsize > 3'd2) begin
                            state <= ERR1;
                            hresp <= RESP_ERROR;
                        end else begin
                            state <= LATCH;
                            hresp <= RESP_OKAY;
                        end
                    end else begin
                        state  <= IDLE;
                        hready <= 1'b1;
                        hresp  <= RESP_OKAY;
                    end
                end

                LATCH: begin
                    pwdata <= hwdata;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end

                SETUP: begin
                    penable <= 1'b1;
                    tcnt    <= '0;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            state <= ERR1;
                            hresp <= RESP_ERROR;
                        end else begin
                            state  <= RESP;
                            hready <= 1'b1;
                            if (!pwrite) hrdata <= prdata;
                        end
                    end else if (TIMEOUT != 0 && 32'(tcnt) == TIMEOUT - 1) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= ERR1;
                        hresp   <= RESP_ERROR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                ERR1: begin
                    state  <= ERR2;
                    hready <= 1'b1;
                    hresp  <= RESP_ERROR;
                end

                default: begin
                    state   <= IDLE;
                    hready  <= 1'b1;
                    hresp   <= RESP_OKAY;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ehl_ahb2apb_bridge.sv
// Scoreboard bench for ehl_ahb2apb_bridge: AHB master stimulus, APB completer model,
// and independent AHB-response and APB-request monitors.
module tb_ehl_ahb2apb_bridge;

    localparam int unsigned TO = 4;

    logic        hclk = 1'b0;
    logic        hresetn, hsel, hwrite;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr, pwdata;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        psel, penable;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        hready_in;

    assign hready_in = hready;

    always #5 hclk = ~hclk;

    ehl_ahb2apb_bridge #(.TIMEOUT(TO)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hready_in(hready_in),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hprot(hprot), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .hrdata(hrdata), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct { bit err; logic [31:0] rdata; int lat; } resp_t;
    typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata;
                     logic [3:0] strb; logic [2:0] prot; int acc; } apb_t;
    typedef struct { int waits; bit err; logic [31:0] rdata; } cpl_t;

    resp_t       rq[$];
    apb_t        aq[$];
    cpl_t        cq[$];
    int          checks = 0;
    int          passes = 0;
    bit          sb_en  = 1'b0;
    logic [31:0] model_hrdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: got no event, required one within the cycle budget", name);
    endtask

    // Reference model: latency/response from the protocol timing rules, strobes from lane arithmetic.
    task automatic issue(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                         input logic [3:0] prot, input logic [31:0] wd,
                         input int waits, input bit err, input logic [31:0] rd);
        resp_t r;
        apb_t  p;
        cpl_t  q;
        int    g, nb, base;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hprot = prot;
        if (sz > 3'd2) begin
            r.err = 1'b1;
            r.lat = 2;
        end else begin
            p.addr  = a;
            p.wr    = wr;
            p.wdata = wd;
            p.prot  = {~prot[0], 1'b1, prot[1]};
            p.strb  = 4'b0000;
            if (wr) begin
                nb   = 1 << int'(sz);
                base = (int'(a[1:0]) / nb) * nb;
                for (int i = 0; i < nb; i++) p.strb[base + i] = 1'b1;
            end
            q.waits = waits; q.err = err; q.rdata = rd;
            if (waits >= int'(TO)) begin
                r.err = 1'b1; r.lat = int'(TO) + 4; p.acc = int'(TO);
            end else if (err) begin
                r.err = 1'b1; r.lat = 5 + waits; p.acc = waits + 1;
            end else begin
                r.err = 1'b0; r.lat = 4 + waits; p.acc = waits + 1;
                if (!wr) model_hrdata = rd;
            end
            aq.push_back(p);
            cq.push_back(q);
        end
        r.rdata = model_hrdata;
        rq.push_back(r);
        g = 0;
        while (!hready && g < 64) begin
            @(posedge hclk); #1;
            g++;
        end
        if (g >= 64) fail_now("accept_wait");
        @(posedge hclk); #1;
        hwdata = wd;
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0:       begin hsel = 1'b1; htrans = 2'b00; end
                1:       begin hsel = 1'b1; htrans = 2'b01; end
                default: begin hsel = 1'b0; htrans = 2'b10; end
            endcase
            haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom);
            @(posedge hclk); #1;
        end
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rq.size() != 0 || aq.size() != 0) && g < 200) begin
            @(posedge hclk); #1;
            g++;
        end
        if (g >= 200) fail_now("drain");
        repeat (2) @(posedge hclk);
        #1;
    endtask

    // APB completer: applies the per-transfer wait count / error chosen by the stimulus.
    initial begin : completer
        cpl_t cfg;
        bit   in_acc;
        int   acnt;
        in_acc = 1'b0; acnt = 0;
        cfg = '{waits: 0, err: 1'b0, rdata: '0};
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(posedge hclk); #1;
            if (psel && penable) begin
                if (!in_acc) begin
                    in_acc = 1'b1; acnt = 0;
                    if (cq.size() == 0) begin
                        fail_now("completer_cfg");
                        cfg = '{waits: 0, err: 1'b0, rdata: '0};
                    end else cfg = cq.pop_front();
                end else acnt++;
                pready  = (acnt == cfg.waits);
                pslverr = pready && cfg.err;
                prdata  = pready ? cfg.rdata : $urandom;
            end else begin
                in_acc  = 1'b0;
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end
    end

    initial begin : ahb_mon
        resp_t      e;
        int         c, start;
        bit         pend;
        logic       last_hready;
        logic [1:0] last_hresp;
        c = 0; start = 0; pend = 1'b0; last_hready = 1'b1; last_hresp = 2'b00;
        forever begin
            @(negedge hclk);
            c++;
            if (!hresetn || !sb_en) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                if (hready) begin
                    if (rq.size() == 0) fail_now("resp_expected");
                    else begin
                        e = rq.pop_front();
                        check("latency", 64'(c - start), 64'(e.lat));
                        check("hresp", 64'(hresp), e.err ? 64'd1 : 64'd0);
                        check("hrdata", 64'(hrdata), 64'(e.rdata));
                        if (e.err) check("err_first_cycle", 64'({last_hready, last_hresp}), 64'(3'b001));
                    end
                    pend = 1'b0;
                end
            end else begin
                check("idle_rsp", 64'({hready, hresp, psel}), 64'(4'b1000));
            end
            if (hsel && hready_in && htrans[1]) begin
                pend = 1'b1;
                start = c;
            end
            last_hready = hready;
            last_hresp  = hresp;
        end
    end

    initial begin : apb_mon
        apb_t cur;
        bit   act, have;
        int   n;
        act = 1'b0; have = 1'b0; n = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn || !sb_en) begin
                act = 1'b0; have = 1'b0; n = 0;
                continue;
            end
            if (psel && !penable) begin
                if (aq.size() == 0) begin
                    fail_now("apb_expected");
                    have = 1'b0;
                end else begin
                    cur = aq.pop_front();
                    have = 1'b1;
                    check("paddr", 64'(paddr), 64'(cur.addr));
                    check("pwrite", 64'(pwrite), 64'(cur.wr));
                    check("pwdata", 64'(pwdata), 64'(cur.wdata));
                    check("pstrb", 64'(pstrb), 64'(cur.strb));
                    check("pprot", 64'(pprot), 64'(cur.prot));
                end
                act = 1'b0; n = 0;
            end else if (psel && penable) begin
                n++;
                act = 1'b1;
                if (have) begin
                    check("hold_paddr", 64'(paddr), 64'(cur.addr));
                    check("hold_ctl", 64'({pwdata, pstrb, pprot, pwrite}),
                          64'({cur.wdata, cur.strb, cur.prot, cur.wr}));
                end
            end else begin
                if (act && have) check("access_cycles", 64'(n), 64'(cur.acc));
                act = 1'b0; n = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got no finish, required completion");
        $fatal(1);
    end

    initial begin : stim
        int          g, r, waits;
        logic [2:0]  sz;
        hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'd0; hprot = 4'h0; hwdata = '0;
        repeat (3) @(posedge hclk);
        #1;
        check("rst_hready", 64'(hready), 64'd1);
        check("rst_hresp", 64'(hresp), 64'd0);
        check("rst_hrdata", 64'(hrdata), 64'd0);
        check("rst_psel_pen", 64'({psel, penable, pwrite}), 64'd0);
        check("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
        check("rst_pstrb_pprot", 64'({pstrb, pprot}), 64'd0);
        hresetn = 1'b1;
        sb_en = 1'b1;
        idle(2);

        issue(32'h1000_0000, 1'b1, 3'd2, 4'h3, 32'h0000_00AA, 0, 1'b0, '0);
        drain();
        issue(32'h3000_0004, 1'b0, 3'd2, 4'h0, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
        drain();
        issue(32'h1000_0003, 1'b1, 3'd0, 4'h1, 32'h7700_0000, 0, 1'b0, '0);
        issue(32'h1000_0002, 1'b1, 3'd1, 4'h2, 32'h5566_0000, 1, 1'b0, '0);
        drain();
        issue(32'h2000_0008, 1'b1, 3'd2, 4'h0, 32'h1234, 0, 1'b1, '0);
        drain();
        issue(32'h2000_000C, 1'b0, 3'd3, 4'h0, 32'h0, 0, 1'b0, '0);
        drain();
        issue(32'h4000_0000, 1'b0, 3'd2, 4'h0, 32'h0, 6, 1'b0, 32'hFFFF_FFFF);
        drain();

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            r  = $urandom_range(0, 9);
            sz = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            waits = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            issue($urandom, 1'($urandom), sz, 4'($urandom), $urandom,
                  waits, ($urandom_range(0, 5) == 0), $urandom);
        end
        drain();

        issue(32'h5000_0010, 1'b0, 3'd2, 4'h0, 32'h0, 0, 1'b0, 32'h1234_5678);
        drain();

        // Reset in the middle of an APB access: no AHB response is owed.
        sb_en = 1'b0;
        cq.push_back('{waits: 20, err: 1'b0, rdata: 32'h55});
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h6000_0000; hwrite = 1'b0; hsize = 3'd2; hprot = 4'h0;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00;
        g = 0;
        while (!(psel && penable) && g < 10) begin
            @(posedge hclk); #1;
            g++;
        end
        if (g >= 10) fail_now("reach_access");
        check("pre_reset_hrdata", 64'(hrdata), 64'(model_hrdata));
        hresetn = 1'b0;
        @(posedge hclk); #1;
        check("mid_rst_psel_pen", 64'({psel, penable}), 64'd0);
        check("mid_rst_hready_hresp", 64'({hready, hresp}), 64'(3'b100));
        check("mid_rst_hrdata", 64'(hrdata), 64'd0);
        check("mid_rst_paddr", 64'(paddr), 64'd0);
        hresetn = 1'b1;
        cq.delete(); aq.delete(); rq.delete();
        model_hrdata = '0;
        @(posedge hclk); #1;
        sb_en = 1'b1;

        issue(32'h7000_0004, 1'b0, 3'd1, 4'h1, 32'h0, 3, 1'b0, 32'hCAFE_F00D);
        drain();
        check("queues_empty", 64'(rq.size() + aq.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
